out_vector_buffer: RTL and testbench

Parametrised successor of the CPU's vector output register. It captures result vectors from the vector datapath into a DEPTH-entry FIFO, with a per-lane write mask and a base address per entry. A drain FSM then writes each entry to data memory lane by lane over a scalar valid/ready port. It also keeps a merged "last vector" view for debug and display consumers.

---
 rtl/out_vector_pkg.sv | 21 ++
 rtl/out_vector_buffer_fifo.sv | 57 +++++
 rtl/out_vector_buffer.sv | 148 ++++++++++++++
 tb/tb_out_vector_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/out_vector_pkg.sv
// out_vector_pkg
//   Shared types and helpers for the output vector buffer.
//   drain_state_t  : drain FSM states
//   BYTE_W         : bits per addressable byte
//   bytes_per_lane : byte stride between consecutive lanes in memory
//   lane_lsb       : bit offset of a lane inside a flattened vector
package out_vector_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, SEND, POP} drain_state_t;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned bytes_per_lane(input int unsigned width);
    return width / BYTE_W;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/out_vector_buffer_fifo.sv
// vec_fifo_mem
//   DEPTH x W register-array FIFO. The caller only pushes when !full and only
//   pops when !empty. rdata always shows the head entry.
//   clk, rst      : clock, synchronous active-high reset (pointers/count only)
//   push, wdata   : write the entry at wr_ptr
//   pop           : retire the head entry
//   rdata         : head entry
//   full, empty   : derived from the registered count
//   count         : occupied entries
module vec_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; an entry is only read once it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/out_vector_buffer.sv
// out_vector_buffer
//   Captures result vectors into a DEPTH-entry FIFO and drains each entry to
//   data memory one enabled lane at a time over a scalar valid/ready port.
//   clk, rst                  : clock, synchronous active-high reset
//   wr_en/wr_mask/wr_data/
//   wr_addr                   : push request, lane enables, vector, base address
//   full, empty, count        : FIFO occupancy
//   ovf                       : sticky, a push arrived while full
//   last_vec                  : merge of the enabled lanes of every accepted push
//   mem_we/mem_addr/mem_data/
//   mem_ready                 : memory write port, transfer on mem_we && mem_ready
//   busy                      : drain FSM not idle
module out_vector_buffer
  import out_vector_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [LANES-1:0]           wr_mask,
  input  logic [LANES*WIDTH-1:0]     wr_data,
  input  logic [ADDR_W-1:0]          wr_addr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic [LANES*WIDTH-1:0]     last_vec,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [WIDTH-1:0]           mem_data,
  input  logic                       mem_ready,
  output logic                       busy
);

  localparam int          CW             = $clog2(DEPTH+1);
  localparam int          LW             = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BYTES_PER_LANE = bytes_per_lane(WIDTH);
  localparam logic [LW-1:0] LAST_LANE    = LW'(LANES-1);

  typedef struct packed {
    logic [ADDR_W-1:0]                 addr;
    logic [LANES-1:0]                  mask;
    logic [LANES-1:0][WIDTH-1:0]       data;
  } entry_t;

  entry_t       wr_ent, head;
  logic         push_ok, pop;
  drain_state_t state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [WIDTH-1:0]  data_d;

  // full is the pre-edge value, so a pop in the same cycle never frees room.
  assign push_ok = wr_en && !full;
  assign wr_ent  = '{addr: wr_addr, mask: wr_mask, data: wr_data};
  assign busy    = (state_q != IDLE);

  vec_fifo_mem #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Lane mask expanded to bit granularity for the last_vec merge.
  logic [LANES*WIDTH-1:0] wbits;
  for (genvar i = 0; i < LANES; i++) begin : g_wbits
    assign wbits[lane_lsb(i, WIDTH) +: WIDTH] = {WIDTH{wr_mask[i]}};
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    we_d    = mem_we;
    addr_d  = mem_addr;
    data_d  = mem_data;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SCAN;
          lane_d  = '0;
        end
      end
      SCAN: begin
        if (head.mask[lane_q]) begin
          addr_d  = head.addr + ADDR_W'(lane_q) * ADDR_W'(BYTES_PER_LANE);
          data_d  = head.data[lane_q];
          we_d    = 1'b1;
          state_d = SEND;
        end else if (lane_q == LAST_LANE) begin
          state_d = POP;
        end else begin
          lane_d  = lane_q + LW'(1);
        end
      end
      SEND: begin
        if (mem_ready) begin
          we_d = 1'b0;
          if (lane_q == LAST_LANE) begin
            state_d = POP;
          end else begin
            lane_d  = lane_q + LW'(1);
            state_d = SCAN;
          end
        end
      end
      POP: begin
        pop    = 1'b1;
        lane_d = '0;
        // A same-edge push keeps the FIFO occupied, so skip IDLE.
        state_d = (count > CW'(1) || push_ok) ? SCAN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      ovf      <= 1'b0;
      last_vec <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      mem_we   <= we_d;
      mem_addr <= addr_d;
      mem_data <= data_d;
      if (wr_en && full) ovf <= 1'b1;
      if (push_ok) last_vec <= (last_vec & ~wbits) | (wr_data & wbits);
    end
  end

endmodule

// File: tb/tb_out_vector_buffer.sv
module tb_out_vector_buffer;

  localparam int LANES  = 4;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       wr_en = 1'b0;
  logic [LANES-1:0]           wr_mask = '0;
  logic [LANES*WIDTH-1:0]     wr_data = '0;
  logic [ADDR_W-1:0]          wr_addr = '0;
  logic                       full, empty, ovf, mem_we, busy;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [LANES*WIDTH-1:0]     last_vec;
  logic [ADDR_W-1:0]          mem_addr;
  logic [WIDTH-1:0]           mem_data;
  logic                       mem_ready = 1'b1;

  out_vector_buffer #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_addr(wr_addr), .full(full), .empty(empty), .count(count), .ovf(ovf),
    .last_vec(last_vec), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Every completed memory transfer, in order.
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  always @(posedge clk) begin
    if (mem_we && mem_ready) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_data);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] m, input logic [127:0] d, input logic [31:0] a);
    wr_en = 1'b1; wr_mask = m; wr_data = d; wr_addr = a;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((busy || !empty) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", 128'({busy, empty}), 128'(2'b01));
  endtask

  task automatic wait_we(input int budget);
    int k;
    k = 0;
    while (!mem_we && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("we_seen", 128'(mem_we), 128'(1));
  endtask

  typedef struct {
    logic [3:0]       mask;
    logic [127:0]     data;
    logic [31:0]      addr;
    int               exp_n;
    logic [3:0][31:0] exp_a;
    logic [3:0][31:0] exp_d;
    logic [127:0]     exp_lv;
    int               exp_lat;
  } vec_t;

  vec_t vt[4];

  initial begin
    int n0, lat;
    logic [31:0] sa, sd;
    logic stable;

    vt[0].mask = 4'b1111; vt[0].addr = 32'h100; vt[0].exp_lat = 2;
    vt[0].data = {32'h44, 32'h33, 32'h22, 32'h11};
    vt[0].exp_n = 4;
    vt[0].exp_a = {32'h10C, 32'h108, 32'h104, 32'h100};
    vt[0].exp_d = {32'h44, 32'h33, 32'h22, 32'h11};
    vt[0].exp_lv = {32'h44, 32'h33, 32'h22, 32'h11};

    vt[1].mask = 4'b0101; vt[1].addr = 32'h200; vt[1].exp_lat = 2;
    vt[1].data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    vt[1].exp_n = 2;
    vt[1].exp_a = {32'h0, 32'h0, 32'h208, 32'h200};
    vt[1].exp_d = {32'h0, 32'h0, 32'hCCCC0002, 32'hAAAA0000};
    vt[1].exp_lv = {32'h44, 32'hCCCC0002, 32'h22, 32'hAAAA0000};

    vt[2].mask = 4'b0000; vt[2].addr = 32'h300; vt[2].exp_lat = -1;
    vt[2].data = {4{32'hFFFFFFFF}};
    vt[2].exp_n = 0;
    vt[2].exp_a = '0;
    vt[2].exp_d = '0;
    vt[2].exp_lv = {32'h44, 32'hCCCC0002, 32'h22, 32'hAAAA0000};

    // Lane 3 address wraps past the top of the address space.
    vt[3].mask = 4'b1000; vt[3].addr = 32'hFFFFFFF8; vt[3].exp_lat = 5;
    vt[3].data = {32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'h12345678};
    vt[3].exp_n = 1;
    vt[3].exp_a = {32'h0, 32'h0, 32'h0, 32'h00000004};
    vt[3].exp_d = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    vt[3].exp_lv = {32'hDEADBEEF, 32'hCCCC0002, 32'h22, 32'hAAAA0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_we", 128'(mem_we), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    chk("rst_last_vec", last_vec, 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single-entry drains
    for (int t = 0; t < 4; t++) begin
      n0 = wa_q.size();
      push(vt[t].mask, vt[t].data, vt[t].addr);
      if (vt[t].exp_lat >= 0) begin
        lat = 0;
        while (!mem_we && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("v%0d_latency", t), 128'(lat), 128'(vt[t].exp_lat));
      end
      wait_drain(100);
      chk($sformatf("v%0d_nwrites", t), 128'(wa_q.size() - n0), 128'(vt[t].exp_n));
      for (int i = 0; i < vt[t].exp_n; i++) begin
        if (n0 + i < wa_q.size()) begin
          chk($sformatf("v%0d_addr%0d", t, i), 128'(wa_q[n0+i]), 128'(vt[t].exp_a[i]));
          chk($sformatf("v%0d_data%0d", t, i), 128'(wd_q[n0+i]), 128'(vt[t].exp_d[i]));
        end
      end
      chk($sformatf("v%0d_last_vec", t), last_vec, vt[t].exp_lv);
    end

    // Backpressure: SEND outputs hold while mem_ready is low
    mem_ready = 1'b0;
    n0 = wa_q.size();
    push(4'b0001, 128'h55, 32'h400);
    wait_we(20);
    sa = mem_addr; sd = mem_data; stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!mem_we || mem_addr !== sa || mem_data !== sd) stable = 1'b0;
    end
    chk("stall_hold", 128'(stable), 128'(1));
    chk("stall_addr", 128'(sa), 128'(32'h400));
    chk("stall_data", 128'(sd), 128'(32'h55));
    mem_ready = 1'b1;
    wait_drain(50);
    chk("stall_nwrites", 128'(wa_q.size() - n0), 128'(1));

    // Fill to DEPTH with the drain stalled, then overflow
    mem_ready = 1'b0;
    n0 = wa_q.size();
    for (int k = 0; k < 4; k++) push(4'b0001, 128'(32'h100 + k), 32'h1000 + 32'(k * 16));
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_count", 128'(count), 128'(4));
    chk("fill_ovf", 128'(ovf), 128'(0));
    push(4'b0001, 128'h1FF, 32'h2000);
    chk("ovf_set", 128'(ovf), 128'(1));
    chk("ovf_count", 128'(count), 128'(4));
    mem_ready = 1'b1;
    wait_drain(200);
    chk("ovf_nwrites", 128'(wa_q.size() - n0), 128'(4));
    for (int k = 0; k < 4; k++) begin
      if (n0 + k < wa_q.size()) begin
        chk($sformatf("ovf_addr%0d", k), 128'(wa_q[n0+k]), 128'(32'h1000 + k * 16));
        chk($sformatf("ovf_data%0d", k), 128'(wd_q[n0+k]), 128'(32'h100 + k));
      end
    end
    chk("ovf_sticky", 128'(ovf), 128'(1));
    chk("ovf_last_vec", last_vec, {32'hDEADBEEF, 32'hCCCC0002, 32'h22, 32'h103});

    // Push landing on the POP edge with count=1
    n0 = wa_q.size();
    push(4'b0001, 128'h77, 32'h500);
    repeat (6) @(negedge clk);
    chk("pop_busy", 128'(busy), 128'(1));
    chk("pop_count", 128'(count), 128'(1));
    push(4'b0001, 128'h88, 32'h600);
    chk("same_edge_count", 128'(count), 128'(1));
    chk("same_edge_busy", 128'(busy), 128'(1));
    chk("same_edge_scan", 128'(mem_we), 128'(0));
    @(negedge clk);
    chk("same_edge_no_idle", 128'(mem_we), 128'(1));
    wait_drain(50);
    chk("same_edge_nwrites", 128'(wa_q.size() - n0), 128'(2));
    if (n0 + 1 < wa_q.size()) begin
      chk("same_edge_addr", 128'(wa_q[n0+1]), 128'(32'h600));
      chk("same_edge_data", 128'(wd_q[n0+1]), 128'(32'h88));
    end

    // Reset while stalled in SEND
    mem_ready = 1'b0;
    push(4'b1111, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h700);
    wait_we(20);
    n0 = wa_q.size();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_mem_we", 128'(mem_we), 128'(0));
    chk("mid_rst_count", 128'(count), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_ovf", 128'(ovf), 128'(0));
    chk("mid_rst_last_vec", last_vec, 128'(0));
    chk("mid_rst_empty", 128'(empty), 128'(1));
    mem_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_writes", 128'(wa_q.size() - n0), 128'(0));
    chk("mid_rst_idle_we", 128'(mem_we), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
